// File: rtl/calendar_pkg.sv
// Shared calendar constants, field widths and month-length helpers used by
// both the up-counting century clock and the countdown timer.
package calendar_pkg;

  localparam int YEAR_W  = 10;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;

  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HOUR_MAX  = 23;
  localparam int DAY_MAX   = 31;
  localparam int MONTH_MAX = 12;
  localparam int YEAR_MAX  = 999;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    is_leap = ((y % 10'd4) == 10'd0) &&
              (((y % 10'd100) != 10'd0) || ((y % 10'd400) == 10'd0));
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] m,
                                                     input logic [YEAR_W-1:0]  y);
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days_in_month = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    days_in_month = 5'd30;
      4'd2:    days_in_month = is_leap(y) ? 5'd29 : 5'd28;
      default: days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/down_counter_mod.sv
// Loadable down-counter for one calendar field: wraps from MIN to reload_val
// and raises borrow on that enabled wrap so the next field steps down.
module down_counter_mod #(
  parameter int W    = 6,
  parameter int MIN  = 0,
  parameter int MAX  = 59,
  parameter int INIT = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  input  logic [W-1:0] reload_val,
  output logic [W-1:0] q,
  output logic [W-1:0] q_next,
  output logic         borrow
);

  localparam logic [W-1:0] MIN_V  = W'(MIN);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic [W-1:0] q_r;
  logic [W-1:0] load_sat_s;
  logic [W-1:0] q_next_s;

  // Saturate the load value into the legal field range
  always_comb begin
    load_sat_s = load_val;
    if (load_val <= MIN_V) begin
      load_sat_s = MIN_V;
    end else if (load_val >= MAX_V) begin
      load_sat_s = MAX_V;
    end else begin
      load_sat_s = load_val;
    end
  end

  // Next count: compare-to-minimum decides wrap, so no subtraction below MIN
  always_comb begin
    q_next_s = q_r;
    if (enable) begin
      if (q_r == MIN_V) begin
        q_next_s = reload_val;
      end else begin
        q_next_s = q_r - W'(1);
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Field register: reset > load > count
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= INIT_V;
    end else if (load) begin
      q_r <= load_sat_s;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q      = q_r;
  assign q_next = q_next_s;
  assign borrow = enable && (q_r == MIN_V);

endmodule

// File: rtl/calendar_countdown.sv
// Calendar countdown timer: loads a date-time, steps it down once per tick with
// a single-cycle borrow ripple, and parks at 000-01-01 00:00:00 flagging expiry.
module calendar_countdown
  import calendar_pkg::*;
#(
  parameter int INIT_YEAR  = 999,
  parameter int INIT_MONTH = 12,
  parameter int INIT_DAY   = 31,
  parameter int INIT_HOUR  = 23,
  parameter int INIT_MIN   = 59,
  parameter int INIT_SEC   = 59
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic [YEAR_W-1:0]  ld_year,
  input  logic [MONTH_W-1:0] ld_month,
  input  logic [DAY_W-1:0]   ld_day,
  input  logic [HOUR_W-1:0]  ld_hour,
  input  logic [MIN_W-1:0]   ld_min,
  input  logic [SEC_W-1:0]   ld_sec,
  output logic [YEAR_W-1:0]  year,
  output logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   day,
  output logic [HOUR_W-1:0]  hour,
  output logic [MIN_W-1:0]   min,
  output logic [SEC_W-1:0]   sec,
  output logic               expired,
  output logic               done
);

  logic [YEAR_W-1:0]  year_r, year_nx_s, ld_year_c_s;
  logic [MONTH_W-1:0] mon_nx_s, ld_month_c_s;
  logic [DAY_W-1:0]   day_nx_s, ld_dim_s, ld_day_c_s, day_reload_s;
  logic [HOUR_W-1:0]  hour_nx_s;
  logic [MIN_W-1:0]   min_nx_s;
  logic [SEC_W-1:0]   sec_nx_s;
  logic sec_b_s, min_b_s, hour_b_s, day_b_s, mon_b_s;
  logic tick_ok_s, at_floor_s, nx_floor_s, ld_floor_s;
  logic expired_r, done_r;

  // Clamp load year/month/day so the day fits the loaded month
  always_comb begin
    ld_year_c_s  = ld_year;
    ld_month_c_s = ld_month;
    if (ld_year >= 10'(YEAR_MAX)) begin
      ld_year_c_s = 10'(YEAR_MAX);
    end else begin
      ld_year_c_s = ld_year;
    end
    if (ld_month == 4'd0) begin
      ld_month_c_s = 4'd1;
    end else if (ld_month >= 4'(MONTH_MAX)) begin
      ld_month_c_s = 4'(MONTH_MAX);
    end else begin
      ld_month_c_s = ld_month;
    end
    ld_dim_s   = days_in_month(ld_month_c_s, ld_year_c_s);
    ld_day_c_s = (ld_day > ld_dim_s) ? ld_dim_s : ld_day;
  end

  // Ticks are ignored once parked at (or reset onto) the floor
  assign at_floor_s = (year_r == 10'd0) && (month == 4'd1) && (day == 5'd1) &&
                      (hour == 5'd0) && (min == 6'd0) && (sec == 6'd0);
  assign tick_ok_s  = tick && !expired_r && !at_floor_s;

  down_counter_mod #(.W(SEC_W), .MIN(0), .MAX(SEC_MAX), .INIT(INIT_SEC)) u_sec (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_sec), .enable(tick_ok_s),
    .reload_val(6'(SEC_MAX)), .q(sec), .q_next(sec_nx_s), .borrow(sec_b_s));

  down_counter_mod #(.W(MIN_W), .MIN(0), .MAX(MIN_MAX), .INIT(INIT_MIN)) u_min (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_min), .enable(sec_b_s),
    .reload_val(6'(MIN_MAX)), .q(min), .q_next(min_nx_s), .borrow(min_b_s));

  down_counter_mod #(.W(HOUR_W), .MIN(0), .MAX(HOUR_MAX), .INIT(INIT_HOUR)) u_hour (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_hour), .enable(min_b_s),
    .reload_val(5'(HOUR_MAX)), .q(hour), .q_next(hour_nx_s), .borrow(hour_b_s));

  // Day wraps to the length of the month it borrows into, so use the resolved next month/year
  assign day_reload_s = days_in_month(mon_nx_s, year_nx_s);

  down_counter_mod #(.W(DAY_W), .MIN(1), .MAX(DAY_MAX), .INIT(INIT_DAY)) u_day (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_day_c_s), .enable(hour_b_s),
    .reload_val(day_reload_s), .q(day), .q_next(day_nx_s), .borrow(day_b_s));

  down_counter_mod #(.W(MONTH_W), .MIN(1), .MAX(MONTH_MAX), .INIT(INIT_MONTH)) u_month (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_month_c_s), .enable(day_b_s),
    .reload_val(4'(MONTH_MAX)), .q(month), .q_next(mon_nx_s), .borrow(mon_b_s));

  // Year has no wrap; a month borrow at year 0 is impossible behind the floor guard
  always_comb begin
    year_nx_s = year_r;
    if (mon_b_s && (year_r != 10'd0)) begin
      year_nx_s = year_r - 10'd1;
    end else begin
      year_nx_s = year_r;
    end
  end

  // Year register: reset > load > count
  always_ff @(posedge clk) begin
    if (reset) begin
      year_r <= 10'(INIT_YEAR);
    end else if (load) begin
      year_r <= ld_year_c_s;
    end else begin
      year_r <= year_nx_s;
    end
  end

  assign nx_floor_s = (year_nx_s == 10'd0) && (mon_nx_s == 4'd1) && (day_nx_s == 5'd1) &&
                      (hour_nx_s == 5'd0) && (min_nx_s == 6'd0) && (sec_nx_s == 6'd0);
  assign ld_floor_s = (ld_year_c_s == 10'd0) && (ld_month_c_s == 4'd1) && (ld_day_c_s <= 5'd1) &&
                      (ld_hour == 5'd0) && (ld_min == 6'd0) && (ld_sec == 6'd0);

  // Expiry level and one-cycle done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      expired_r <= 1'b0;
      done_r    <= 1'b0;
    end else if (load) begin
      expired_r <= ld_floor_s;
      done_r    <= 1'b0;
    end else if (tick_ok_s && nx_floor_s) begin
      expired_r <= 1'b1;
      done_r    <= 1'b1;
    end else begin
      done_r    <= 1'b0;
    end
  end

  assign year    = year_r;
  assign expired = expired_r;
  assign done    = done_r;

endmodule

// File: tb/tb_calendar_countdown.sv
// Scoreboard bench for calendar_countdown: directed stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares them against the DUT.
module tb_calendar_countdown;

  logic       clk = 1'b0;
  logic       reset, tick, load;
  logic [9:0] ld_year;
  logic [3:0] ld_month;
  logic [4:0] ld_day, ld_hour;
  logic [5:0] ld_min, ld_sec;
  logic [9:0] year;
  logic [3:0] month;
  logic [4:0] day, hour;
  logic [5:0] min, sec;
  logic       expired, done;

  always #5 clk = ~clk;

  calendar_countdown dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day),
    .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
    .year(year), .month(month), .day(day), .hour(hour), .min(min), .sec(sec),
    .expired(expired), .done(done));

  typedef struct {
    logic [9:0] y;
    logic [3:0] mo;
    logic [4:0] d;
    logic [4:0] h;
    logic [5:0] mi;
    logic [5:0] s;
    logic       ex;
    logic       dn;
    int         tag;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the expectation due for this cycle
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].tag <= cyc) begin
      mon_e = sbq.pop_front();
      total++;
      if ({year, month, day, hour, min, sec, expired, done} !==
          {mon_e.y, mon_e.mo, mon_e.d, mon_e.h, mon_e.mi, mon_e.s, mon_e.ex, mon_e.dn}) begin
        bad++;
        $display("FAIL %s: got %0d-%0d-%0d %0d:%0d:%0d exp=%0b done=%0b, want %0d-%0d-%0d %0d:%0d:%0d exp=%0b done=%0b",
                 mon_e.nm, year, month, day, hour, min, sec, expired, done,
                 mon_e.y, mon_e.mo, mon_e.d, mon_e.h, mon_e.mi, mon_e.s, mon_e.ex, mon_e.dn);
      end
    end
  end

  task automatic setld(input int y, input int mo, input int d, input int h, input int mi, input int s);
    ld_year  = 10'(y);
    ld_month = 4'(mo);
    ld_day   = 5'(d);
    ld_hour  = 5'(h);
    ld_min   = 6'(mi);
    ld_sec   = 6'(s);
  endtask

  // One clock of stimulus plus the state expected right after that edge
  task automatic go(input logic r, input logic l, input logic t, input string nm,
                    input int y, input int mo, input int d, input int h, input int mi, input int s,
                    input logic ex, input logic dn);
    exp_t e;
    e.y = 10'(y); e.mo = 4'(mo); e.d = 5'(d); e.h = 5'(h); e.mi = 6'(mi); e.s = 6'(s);
    e.ex = ex; e.dn = dn; e.tag = cyc + 1; e.nm = nm;
    sbq.push_back(e);
    reset = r; load = l; tick = t;
    @(posedge clk);
    #1;
    reset = 1'b0; load = 1'b0; tick = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b0; load = 1'b0; tick = 1'b0;
    setld(0, 1, 1, 0, 0, 0);
    @(posedge clk);
    #1;

    go(1'b1, 1'b0, 1'b0, "reset",   999, 12, 31, 23, 59, 59, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "tick1",   999, 12, 31, 23, 59, 58, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, "idle",    999, 12, 31, 23, 59, 58, 1'b0, 1'b0);

    setld(4, 3, 1, 0, 0, 0);
    go(1'b0, 1'b1, 1'b0, "ld004",     4, 3, 1, 0, 0, 0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "leap004",   4, 2, 29, 23, 59, 59, 1'b0, 1'b0);
    setld(100, 3, 1, 0, 0, 0);
    go(1'b0, 1'b1, 1'b0, "ld100",   100, 3, 1, 0, 0, 0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "feb100",  100, 2, 28, 23, 59, 59, 1'b0, 1'b0);
    setld(400, 3, 1, 0, 0, 0);
    go(1'b0, 1'b1, 1'b0, "ld400",   400, 3, 1, 0, 0, 0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "leap400", 400, 2, 29, 23, 59, 59, 1'b0, 1'b0);
    setld(5, 5, 1, 0, 0, 0);
    go(1'b0, 1'b1, 1'b0, "ld005",     5, 5, 1, 0, 0, 0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "apr30",     5, 4, 30, 23, 59, 59, 1'b0, 1'b0);

    setld(1, 1, 1, 0, 0, 0);
    go(1'b0, 1'b1, 1'b0, "ld001",     1, 1, 1, 0, 0, 0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "ripple",    0, 12, 31, 23, 59, 59, 1'b0, 1'b0);

    setld(0, 1, 1, 0, 0, 2);
    go(1'b0, 1'b1, 1'b0, "ldnear",    0, 1, 1, 0, 0, 2, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "near1",     0, 1, 1, 0, 0, 1, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "floor",     0, 1, 1, 0, 0, 0, 1'b1, 1'b1);
    go(1'b0, 1'b0, 1'b0, "donefall",  0, 1, 1, 0, 0, 0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b1, "parked",    0, 1, 1, 0, 0, 0, 1'b1, 1'b0);

    setld(3, 2, 31, 0, 0, 0);
    go(1'b0, 1'b1, 1'b1, "clampprio", 3, 2, 28, 0, 0, 0, 1'b0, 1'b0);
    setld(0, 1, 1, 0, 0, 0);
    go(1'b0, 1'b1, 1'b0, "ldfloor",   0, 1, 1, 0, 0, 0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b1, "ldfloortk", 0, 1, 1, 0, 0, 0, 1'b1, 1'b0);
    setld(2, 15, 31, 30, 61, 63);
    go(1'b0, 1'b1, 1'b0, "saturate",  2, 12, 31, 23, 59, 59, 1'b0, 1'b0);
    setld(200, 2, 29, 5, 0, 0);
    go(1'b0, 1'b1, 1'b0, "clamp200", 200, 2, 28, 5, 0, 0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "hourbrw",  200, 2, 28, 4, 59, 59, 1'b0, 1'b0);

    setld(5, 6, 15, 10, 20, 30);
    go(1'b0, 1'b1, 1'b0, "ldmid",     5, 6, 15, 10, 20, 30, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "midtick",   5, 6, 15, 10, 20, 29, 1'b0, 1'b0);
    go(1'b1, 1'b1, 1'b1, "rstmid",  999, 12, 31, 23, 59, 59, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b1, "postrst", 999, 12, 31, 23, 59, 58, 1'b0, 1'b0);

    w = 0;
    while (sbq.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calendar_countdown.md
# calendar_countdown

Decrementing calendar timer. It counts the same second/minute/hour/day/month/year fields as the up-counting century clock, but runs them in the other direction with borrow propagation instead of carry. It is loadable with a start date-time and counts down once per enable tick to the floor 000-01-01 00:00:00, where it stops and flags expiry. It sits beside the century clock and shares its 1 Hz enable source; its binary field outputs feed the same BCD/7-segment display path.

## Interface
Parameters:
- `INIT_YEAR`, 999: reset value of the year, range 0..999.
- `INIT_MONTH`, 12: reset value of the month, range 1..12.
- `INIT_DAY`, 31: reset value of the day; must be valid for `INIT_MONTH`/`INIT_YEAR`.
- `INIT_HOUR`, 23: reset value of the hour.
- `INIT_MIN`, 59: reset value of the minute.
- `INIT_SEC`, 59: reset value of the second.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle count-down enable (1 Hz strobe).
- `load`  in  1  load the `ld_*` fields on this edge.
- `ld_year`  in  10  load value, 0..999.
- `ld_month`  in  4  load value, 1..12.
- `ld_day`  in  5  load value, 1..31.
- `ld_hour`  in  5  load value, 0..23.
- `ld_min`  in  6  load value, 0..59.
- `ld_sec`  in  6  load value, 0..59.
- `year`, `month`, `day`, `hour`, `min`, `sec`  out  10/4/5/5/6/6  current value, registered.
- `expired`  out  1  level; high while the count is parked at the floor.
- `done`  out  1  one-cycle pulse on the cycle the floor is reached.

## Operation
- **Reset.** Fields take their INIT_* values. `expired`=0, `done`=0.
- **Priority.** `reset` > `load` > `tick`. If `load` and `tick` are high together, the load wins and the tick is dropped.
- **Load.**
  - Fields are captured directly.
  - `ld_day` is clamped to days_in_month(`ld_month`, `ld_year`).
  - `ld_month` of 0 loads as 1; a value above 12 loads as 12. `ld_hour`, `ld_min`, `ld_sec` that are out of range saturate to 23/59/59.
  - `expired` is recomputed: it is 1 only if the loaded value equals the floor. `done` is not pulsed on a load.
- **Tick while not expired.** Decrement with a borrow chain:
  - sec: if 0, becomes 59 and borrows to min; otherwise sec-1.
  - min: same as sec, 0 → 59, borrows to hour.
  - hour: 0 → 23, borrows to day.
  - day: if 1, becomes days_in_month of the *new* month (after the month borrow resolves) and borrows to month.
  - month: 1 → 12, borrows to year.
  - year: year-1.
- **Floor.** If the tick moves the count from 000-01-01 00:00:01 to 000-01-01 00:00:00, set `expired`=1 and pulse `done`=1 on the next cycle.
- **Tick while expired.** Ignored. Fields hold, and there is no wrap to 999.
- **days_in_month(m, y).**
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if leap, else 28.
  - Leap = (y%4==0) && (y%100!=0 || y%400==0). Year 0 is leap; 100, 200, 300 are not; 400 and 800 are.
- **Width rules.** Each field's borrow is a pure compare-to-minimum. Never compute a field by subtracting into a negative value.

## Timing
- All outputs are registered. A tick or load sampled at edge N is visible after edge N.
- `done` is high exactly one cycle, on the cycle after the edge that reached the floor; `expired` rises on that same cycle.
- A full borrow ripple (e.g. 001-01-01 00:00:00 → 000-12-31 23:59:59) resolves in a single cycle. There is no multi-cycle ripple.
- Back-to-back ticks on consecutive cycles are supported.
- `reset` mid-countdown takes effect on the next edge and overrides any `load` or `tick` in the same cycle.

## Structure
- **Package `calendar_pkg`.**
  - Constants: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12, YEAR_MAX=999.
  - Field widths.
  - The `is_leap(y)` and `days_in_month(m, y)` functions. These are shared with the up-counting clock's month/day logic.
- **Sub-module `down_counter_mod`.**
  - Parameters MIN, MAX.
  - Inputs: `enable`, `reload_val`, `load`.
  - Outputs: `q`, `borrow`.
  - Used for sec/min/hour, and for month and day; the day instance takes `reload_val` from `days_in_month`.
- **Top level.** Holds the priority mux, the floor compare, and the `expired`/`done` registers.

## Test plan
- **Reset and default countdown.** Reset, then apply 1 tick → 999-12-31 23:59:58, `expired`=0.
- **Leap February borrow.** Load 004-03-01 00:00:00, apply 1 tick → 004-02-29 23:59:59. Load 100-03-01 00:00:00, apply 1 tick → 100-02-28 23:59:59. Load 400-03-01 00:00:00, apply 1 tick → 400-02-29 23:59:59.
- **Full borrow ripple.** Load 001-01-01 00:00:00, apply 1 tick → 000-12-31 23:59:59 in one cycle.
- **Floor.** Load 000-01-01 00:00:02, apply 3 ticks. Second tick → floor, `done` high for 1 cycle, `expired`=1. Third tick → fields unchanged, no `done`.
- **Load clamp and priority.** Load 003-02-31 with `tick` high in the same cycle → 003-02-28 00:00:00 (with zero time fields loaded), tick dropped. Load the floor directly → `expired`=1, `done`=0.
- **Reset mid-operation.** Reset asserted together with `load` and `tick` partway through a countdown → INIT values next cycle, `expired`=0, `done`=0.
